// File: rtl/router_pkg.sv
// Shared definitions for the router packet protocol: state encoding,
// field widths and the header byte layout.
package router_pkg;

   localparam int PKT_DATA_W   = 8;
   localparam int PKT_LEN_W    = 6;
   localparam int PKT_MAX_ADDR = 2;

   localparam int HDR_ADDR_LSB = 0;
   localparam int HDR_ADDR_MSB = 1;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_LEN_MSB  = 7;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FILL    = 3'd1,
      ST_HEADER  = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_PARITY  = 3'd4,
      ST_DONE    = 3'd5
   } tx_state_e;

   function automatic logic [PKT_DATA_W-1:0] make_header(
      input logic [PKT_LEN_W-1:0] len,
      input logic [1:0]           addr
   );
      logic [PKT_DATA_W-1:0] h;
      h = '0;
      h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
      h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
      return h;
   endfunction

endpackage

// File: rtl/pkt_tx_buf.sv
// Payload staging buffer: synchronous write, asynchronous read, no reset on
// the storage array.
module pkt_tx_buf #(
   parameter int DATA_W = 8,
   parameter int AW     = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pkt_tx.sv
// Packet source for the router input port: buffers a payload, then sends
// header, payload and parity while honouring the router's busy signal.
//
// state   | meaning
// IDLE    | waiting for start; rejects illegal destinations with err
// FILL    | accepting payload bytes into the buffer
// HEADER  | presenting {len,addr} with pkt_valid
// PAYLOAD | presenting buffered bytes with pkt_valid
// PARITY  | presenting running XOR with pkt_valid low
// DONE    | one-cycle done pulse, then back to IDLE
module pkt_tx
   import router_pkg::*;
#(
   parameter int DATA_W   = PKT_DATA_W,
   parameter int LEN_W    = PKT_LEN_W,
   parameter int DEPTH    = 2**PKT_LEN_W,
   parameter int MAX_ADDR = PKT_MAX_ADDR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        dest_addr,
   input  logic [LEN_W-1:0]  pay_len,
   input  logic              pld_valid,
   input  logic [DATA_W-1:0] pld_data,
   output logic              pld_ready,
   input  logic              busy,
   input  logic              abort,
   output logic [DATA_W-1:0] data_out,
   output logic              pkt_valid,
   output logic              tx_idle,
   output logic              done,
   output logic              err
);

   tx_state_e         state_q, state_d;
   logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] parity_q, parity_d;
   logic [1:0]        addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              err_q, err_d;

   logic              wr_en;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] hdr;
   logic [LEN_W-1:0]  len_m1;

   assign hdr    = make_header(len_q, addr_q);
   assign len_m1 = len_q - 1'b1;

   pkt_tx_buf #(
      .DATA_W (DATA_W),
      .AW     (LEN_W),
      .DEPTH  (DEPTH)
   ) u_buf (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (pld_data),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         parity_q <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         parity_q <= parity_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      parity_d  = parity_q;
      addr_d    = addr_q;
      len_d     = len_q;
      err_d     = 1'b0;
      wr_en     = 1'b0;
      data_out  = '0;
      pkt_valid = 1'b0;
      pld_ready = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (dest_addr > 2'(MAX_ADDR)) begin
                  err_d = 1'b1;
               end else begin
                  addr_d   = dest_addr;
                  len_d    = pay_len;
                  parity_d = '0;
                  wr_ptr_d = '0;
                  rd_ptr_d = '0;
                  state_d  = (pay_len != '0) ? ST_FILL : ST_HEADER;
               end
            end
         end
         ST_FILL: begin
            pld_ready = 1'b1;
            if (pld_valid) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (wr_ptr_q == len_m1) begin
                  state_d = ST_HEADER;
               end
            end
         end
         ST_HEADER: begin
            pkt_valid = 1'b1;
            data_out  = hdr;
            if (!busy) begin
               parity_d = parity_q ^ hdr;
               state_d  = (len_q != '0) ? ST_PAYLOAD : ST_PARITY;
            end
         end
         ST_PAYLOAD: begin
            pkt_valid = 1'b1;
            data_out  = rd_data;
            if (!busy) begin
               parity_d = parity_q ^ rd_data;
               rd_ptr_d = rd_ptr_q + 1'b1;
               if (rd_ptr_q == len_m1) begin
                  state_d = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            data_out = parity_q;
            if (!busy) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abandon wins over every normal transition; the buffer write is dropped too.
      if (abort && (state_q != ST_IDLE)) begin
         state_d  = ST_IDLE;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         wr_en    = 1'b0;
      end
   end

   assign tx_idle = (state_q == ST_IDLE);
   assign done    = (state_q == ST_DONE);
   assign err     = err_q;

endmodule

// File: tb/tb_pkt_tx.sv
// Directed bench for pkt_tx: transmitted bytes are checked against a
// scoreboard filled from a reference model when each packet is started.
module tb_pkt_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] dest_addr;
   logic [5:0] pay_len;
   logic       pld_valid;
   logic [7:0] pld_data;
   logic       pld_ready;
   logic       busy;
   logic       abort;
   logic [7:0] data_out;
   logic       pkt_valid;
   logic       tx_idle;
   logic       done;
   logic       err;

   int         tests    = 0;
   int         fails    = 0;
   int         consumed = 0;
   logic [8:0] sb [$];
   logic [7:0] pay [64];
   logic       rdy_seen;

   pkt_tx dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dest_addr (dest_addr),
      .pay_len   (pay_len),
      .pld_valid (pld_valid),
      .pld_data  (pld_data),
      .pld_ready (pld_ready),
      .busy      (busy),
      .abort     (abort),
      .data_out  (data_out),
      .pkt_valid (pkt_valid),
      .tx_idle   (tx_idle),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // A byte is on the wire while pkt_valid is high or during the parity slot.
   always @(negedge clk) begin
      logic [8:0] exp;
      if (pld_ready) rdy_seen = 1'b1;
      if (!reset && !busy && (pkt_valid || (!tx_idle && !pld_ready && !done))) begin
         consumed++;
         if (sb.size() == 0) begin
            check("unexpected_byte", sb.size(), 1);
         end else begin
            exp = sb.pop_front();
            check("byte", {pkt_valid, data_out}, exp);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pkt(input logic [1:0] a, input int len);
      logic [7:0] h;
      logic [7:0] p;
      h = {6'(len), a};
      p = h;
      sb.push_back({1'b1, h});
      for (int i = 0; i < len; i++) begin
         sb.push_back({1'b1, pay[i]});
         p = p ^ pay[i];
      end
      sb.push_back({1'b0, p});
   endtask

   task automatic start_pkt(input logic [1:0] a, input int len);
      start     = 1'b1;
      dest_addr = a;
      pay_len   = 6'(len);
      tick();
      start = 1'b0;
      for (int i = 0; i < len; i++) begin
         check("pld_ready_fill", pld_ready, 1);
         pld_valid = 1'b1;
         pld_data  = pay[i];
         tick();
      end
      pld_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 300; i++) begin
         if (done) break;
         tick();
      end
      check("done_seen", done, 1);
      tick();
      check("done_pulse_width", done, 0);
      check("idle_after_done", tx_idle, 1);
   endtask

   initial begin
      int c0;
      reset     = 1'b1;
      start     = 1'b0;
      dest_addr = '0;
      pay_len   = '0;
      pld_valid = 1'b0;
      pld_data  = '0;
      busy      = 1'b0;
      abort     = 1'b0;
      rdy_seen  = 1'b0;
      #1;
      check("rst_data_out", data_out, 0);
      check("rst_pkt_valid", pkt_valid, 0);
      check("rst_pld_ready", pld_ready, 0);
      check("rst_tx_idle", tx_idle, 1);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // basic packet
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
      c0 = consumed;
      push_pkt(2'd1, 3);
      start_pkt(2'd1, 3);
      wait_done();
      check("basic_bytes", consumed - c0, 5);
      check("basic_sb_empty", sb.size(), 0);

      // zero-length packet
      tick();
      rdy_seen = 1'b0;
      c0 = consumed;
      push_pkt(2'd2, 0);
      start_pkt(2'd2, 0);
      wait_done();
      check("len0_bytes", consumed - c0, 2);
      check("len0_no_ready", rdy_seen, 0);

      // back-pressure while 0x22 is presented
      tick();
      c0 = consumed;
      push_pkt(2'd1, 3);
      start_pkt(2'd1, 3);
      for (int i = 0; i < 20; i++) begin
         if (pkt_valid && data_out == 8'h22) break;
         tick();
      end
      check("busy_found_22", data_out, 8'h22);
      busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("busy_hold_data", data_out, 8'h22);
         check("busy_hold_valid", pkt_valid, 1);
      end
      busy = 1'b0;
      wait_done();
      check("busy_bytes", consumed - c0, 5);

      // illegal destination
      tick();
      start     = 1'b1;
      dest_addr = 2'd3;
      pay_len   = 6'd5;
      tick();
      start = 1'b0;
      check("err_pulse", err, 1);
      check("err_idle", tx_idle, 1);
      check("err_pkt_valid", pkt_valid, 0);
      check("err_pld_ready", pld_ready, 0);
      tick();
      check("err_cleared", err, 0);
      check("err_still_idle", tx_idle, 1);

      // abort after header and two of four payload bytes
      pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3; pay[3] = 8'hA4;
      c0 = consumed;
      sb.push_back({1'b1, 8'h11});
      sb.push_back({1'b1, 8'hA1});
      sb.push_back({1'b1, 8'hA2});
      start_pkt(2'd1, 4);
      for (int i = 0; i < 20; i++) begin
         if (consumed - c0 >= 3) break;
         tick();
      end
      check("abort_pre_bytes", consumed - c0, 3);
      busy  = 1'b1;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      busy  = 1'b0;
      check("abort_idle", tx_idle, 1);
      check("abort_pkt_valid", pkt_valid, 0);
      check("abort_no_done", done, 0);
      check("abort_sb_empty", sb.size(), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abort_still_no_done", done, 0);
      end
      pay[0] = 8'h5A;
      c0 = consumed;
      push_pkt(2'd0, 1);
      start_pkt(2'd0, 1);
      wait_done();
      check("post_abort_bytes", consumed - c0, 3);

      // asynchronous reset in the middle of FILL
      tick();
      start     = 1'b1;
      dest_addr = 2'd1;
      pay_len   = 6'd4;
      tick();
      start     = 1'b0;
      pld_valid = 1'b1;
      pld_data  = 8'h77;
      tick();
      tick();
      #3;
      reset = 1'b1;
      #1;
      check("mid_rst_idle", tx_idle, 1);
      check("mid_rst_pld_ready", pld_ready, 0);
      check("mid_rst_pkt_valid", pkt_valid, 0);
      check("mid_rst_data_out", data_out, 0);
      pld_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();

      // maximum length packet
      for (int i = 0; i < 63; i++) pay[i] = 8'(i);
      c0 = consumed;
      push_pkt(2'd0, 63);
      start_pkt(2'd0, 63);
      wait_done();
      check("max_len_bytes", consumed - c0, 65);
      check("final_sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
